// File: rtl/spm_arb_pkg.sv
// Shared types and constants for the scratch-pad memory arbiter.
package spm_arb_pkg;

  // Read/write encodings on the SPM command bus, matching the global bus defines.
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Width of the IF starvation counter.
  localparam int CNT_W = 4;

  // Owner of the read whose data returns on the following cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  // Run/drain/halt sequencer states.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_DRAIN = 2'd1,
    MODE_HALT  = 2'd2
  } mode_e;

endpackage : spm_arb_pkg

// File: rtl/spm_arb_starve_ctr.sv
// IF starvation counter. Counts RUN cycles in which IF asks for the SPM and
// loses to MEM. Once it reaches STARVE_LIMIT, IF is promoted above MEM for
// that cycle. Only built when SPM_ARB_FAIRNESS_EN is defined.
module spm_arb_starve_ctr
  import spm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic if_req_i,
  input  logic if_gnt_i,
  output logic promote_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear outside RUN or when IF wins, otherwise count denials up to the limit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (!run_i || if_gnt_i) begin
      cnt_d = '0;
    end else if (if_req_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign promote_o = (cnt_q == LIMIT);

endmodule : spm_arb_starve_ctr

// File: rtl/spm_arbiter.sv
// Per-cycle arbiter for the single-ported scratch-pad memory shared by
// instruction fetch (IF), load/store (MEM) and the debug port (DBG).
// A RUN/DRAIN/HALT sequencer lets an in-flight CPU read return before debug
// gets the port. Define SPM_ARB_FAIRNESS_EN to promote a starved IF over MEM.
module spm_arbiter
  import spm_arb_pkg::*;
#(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_stall,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              dbg_req,
  input  logic              dbg_rw,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [ADDR_W-1:0] spm_addr,
  output logic [DATA_W-1:0] spm_wdata,
  input  logic [DATA_W-1:0] spm_rdata
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("spm_arbiter: STARVE_LIMIT must be in 1..15");
  end

  mode_e  state_q;
  owner_e owner_q, owner_d;
  logic   promote;
  logic   rd_issue;

`ifdef SPM_ARB_FAIRNESS_EN
  spm_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .reset     (reset),
    .run_i     (state_q == MODE_RUN),
    .if_req_i  (if_req),
    .if_gnt_i  (if_gnt),
    .promote_o (promote)
  );
`else
  assign promote = 1'b0;
`endif

  // Grant selection from the current mode and requests; one grant at most.
  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    dbg_gnt = 1'b0;
    unique case (state_q)
      MODE_RUN: begin
        if (promote && if_req) if_gnt  = 1'b1;
        else if (mem_req)      mem_gnt = 1'b1;
        else if (if_req)       if_gnt  = 1'b1;
      end
      MODE_HALT: dbg_gnt = dbg_req;
      default:   ;
    endcase
  end

  // Drive the SPM command from the winner and note who owns the returning read.
  always_comb begin
    spm_as_   = 1'b1;
    spm_rw    = READ;
    spm_addr  = '0;
    spm_wdata = '0;
    owner_d   = OWN_NONE;
    if (if_gnt) begin
      spm_as_  = 1'b0;
      spm_addr = if_addr;
      owner_d  = OWN_IF;
    end else if (mem_gnt) begin
      spm_as_   = 1'b0;
      spm_rw    = mem_rw;
      spm_addr  = mem_addr;
      spm_wdata = mem_wdata;
      if (mem_rw == READ) owner_d = OWN_MEM;
    end else if (dbg_gnt) begin
      spm_as_   = 1'b0;
      spm_rw    = dbg_rw;
      spm_addr  = dbg_addr;
      spm_wdata = dbg_wdata;
      if (dbg_rw == READ) owner_d = OWN_DBG;
    end
  end

  // A read issued this cycle is still in flight after the coming edge.
  assign rd_issue = (owner_d != OWN_NONE);

  // Mode sequencer and read-owner register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears the owner, so a read in flight at reset never returns.
    if (reset) begin
      state_q <= MODE_HALT;
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
      unique case (state_q)
        MODE_RUN: begin
          if (!cpu_en) state_q <= rd_issue ? MODE_DRAIN : MODE_HALT;
        end
        MODE_DRAIN: state_q <= MODE_HALT;
        MODE_HALT: begin
          if (cpu_en) state_q <= MODE_RUN;
        end
        default: state_q <= MODE_HALT;
      endcase
    end
  end

  assign if_stall  = if_req  & ~if_gnt;
  assign mem_stall = mem_req & ~mem_gnt;

  // Response steering: only the registered owner sees valid data, and never during reset.
  assign if_rvalid  = ~reset & (owner_q == OWN_IF);
  assign mem_rvalid = ~reset & (owner_q == OWN_MEM);
  assign dbg_rvalid = ~reset & (owner_q == OWN_DBG);
  assign if_rdata   = if_rvalid  ? spm_rdata : '0;
  assign mem_rdata  = mem_rvalid ? spm_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? spm_rdata : '0;

endmodule : spm_arbiter

// File: tb/tb_spm_arbiter.sv
// Directed testbench for spm_arbiter with a small synchronous SPM model.
module tb_spm_arbiter;
  import spm_arb_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
`ifdef SPM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, cpu_en;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_stall, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          mem_req, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_stall, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          dbg_req, dbg_rw;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          spm_as_, spm_rw;
  logic [AW-1:0] spm_addr;
  logic [DW-1:0] spm_wdata;
  logic [DW-1:0] spm_rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] mem [0:255];

  always #5 clk = ~clk;

  spm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_req(dbg_req), .dbg_rw(dbg_rw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr), .spm_wdata(spm_wdata),
    .spm_rdata(spm_rdata)
  );

  // Synchronous single-port SPM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (!spm_as_) begin
      if (spm_rw == WRITE) mem[spm_addr[7:0]] <= spm_wdata;
      spm_rdata <= mem[spm_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_en = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_rw = READ; mem_addr = '0; mem_wdata = '0;
    dbg_req = 1'b0; dbg_rw = READ; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick(); #3;
    n_total++; if (spm_as_ !== 1'b1) $display("FAIL rst_spm_as: got %b want 1", spm_as_); else n_pass++;
    n_total++; if ({if_rvalid, mem_rvalid, dbg_rvalid} !== 3'b000)
      $display("FAIL rst_rvalid: got %b want 000", {if_rvalid, mem_rvalid, dbg_rvalid}); else n_pass++;
    n_total++; if ((if_rdata | mem_rdata | dbg_rdata) !== '0)
      $display("FAIL rst_rdata: got %h want 0", if_rdata | mem_rdata | dbg_rdata); else n_pass++;
    n_total++; if ({spm_rw, spm_addr, spm_wdata} !== {READ, {AW{1'b0}}, {DW{1'b0}}})
      $display("FAIL rst_spm_cmd: got rw=%b addr=%h wdata=%h", spm_rw, spm_addr, spm_wdata); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    cpu_en = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 30'h10;
    #3;
    n_total++; if (if_gnt !== 1'b1) $display("FAIL ifrd_gnt: got %b want 1", if_gnt); else n_pass++;
    n_total++; if ({spm_as_, spm_rw, spm_addr} !== {1'b0, READ, 30'h10})
      $display("FAIL ifrd_cmd: got as=%b rw=%b addr=%h want 0 1 10", spm_as_, spm_rw, spm_addr); else n_pass++;
    tick();
    if_req = 1'b0;
    #3;
    n_total++; if (if_rvalid !== 1'b1) $display("FAIL ifrd_rvalid: got %b want 1", if_rvalid); else n_pass++;
    n_total++; if (if_rdata !== 32'hDEADBEEF) $display("FAIL ifrd_rdata: got %h want deadbeef", if_rdata); else n_pass++;
    n_total++; if (mem_rdata !== 32'h0) $display("FAIL ifrd_mem_rdata: got %h want 0", mem_rdata); else n_pass++;
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 30'h10;
    mem_req = 1'b1; mem_rw = WRITE; mem_addr = 30'h20; mem_wdata = 32'h55;
    #3;
    n_total++; if ({mem_gnt, if_gnt, if_stall, mem_stall} !== 4'b1010)
      $display("FAIL prio_gnt: got mg=%b ig=%b is=%b ms=%b want 1 0 1 0", mem_gnt, if_gnt, if_stall, mem_stall); else n_pass++;
    n_total++; if ({spm_rw, spm_addr, spm_wdata} !== {WRITE, 30'h20, 32'h55})
      $display("FAIL prio_cmd: got rw=%b addr=%h wdata=%h want 0 20 55", spm_rw, spm_addr, spm_wdata); else n_pass++;
    tick();
    mem_req = 1'b0;
    #3;
    n_total++; if ({if_gnt, if_stall} !== 2'b10) $display("FAIL prio_if_next: got gnt=%b stall=%b want 1 0", if_gnt, if_stall); else n_pass++;
    n_total++; if (mem_rvalid !== 1'b0) $display("FAIL prio_wr_no_rvalid: got %b want 0", mem_rvalid); else n_pass++;
    tick();
    if_req = 1'b0; cpu_en = 1'b0;
    tick();
    dbg_req = 1'b1; dbg_rw = READ; dbg_addr = 30'h20;
    #3;
    n_total++; if ({dbg_gnt, spm_addr} !== {1'b1, 30'h20}) $display("FAIL halt_dbg_gnt: got gnt=%b addr=%h want 1 20", dbg_gnt, spm_addr); else n_pass++;
    tick();
    dbg_req = 1'b0;
    #3;
    n_total++; if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'h55}) $display("FAIL halt_dbg_rdata: got v=%b d=%h want 1 55", dbg_rvalid, dbg_rdata); else n_pass++;
    n_total++; if (if_rdata !== 32'h0) $display("FAIL halt_if_rdata: got %h want 0", if_rdata); else n_pass++;
  endtask

  task automatic test_drain();
    cpu_en = 1'b1;
    tick();
    mem_req = 1'b1; mem_rw = READ; mem_addr = 30'h10; cpu_en = 1'b0;
    #3;
    n_total++; if (mem_gnt !== 1'b1) $display("FAIL drain_mem_gnt: got %b want 1", mem_gnt); else n_pass++;
    tick();
    mem_req = 1'b0; dbg_req = 1'b1; dbg_rw = READ; dbg_addr = 30'h20;
    #3;
    n_total++; if ({mem_rvalid, mem_rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL drain_rvalid: got v=%b d=%h want 1 deadbeef", mem_rvalid, mem_rdata); else n_pass++;
    n_total++; if ({dbg_gnt, spm_as_} !== 2'b01) $display("FAIL drain_no_gnt: got dbg_gnt=%b as_=%b want 0 1", dbg_gnt, spm_as_); else n_pass++;
    tick();
    #3;
    n_total++; if (dbg_gnt !== 1'b1) $display("FAIL drain_halt_dbg: got %b want 1", dbg_gnt); else n_pass++;
    tick();
    dbg_req = 1'b0;
    #3;
    n_total++; if (dbg_rdata !== 32'h55) $display("FAIL drain_dbg_rdata: got %h want 55", dbg_rdata); else n_pass++;
  endtask

  task automatic test_halt_stall();
    if_req = 1'b1; mem_req = 1'b1; mem_rw = READ;
    #3;
    n_total++; if ({if_gnt, mem_gnt, if_stall, mem_stall, dbg_gnt} !== 5'b00110)
      $display("FAIL halt_stall: got ig=%b mg=%b is=%b ms=%b dg=%b want 0 0 1 1 0", if_gnt, mem_gnt, if_stall, mem_stall, dbg_gnt); else n_pass++;
    dbg_req = 1'b1; dbg_rw = WRITE; dbg_addr = 30'h30; dbg_wdata = 32'hA5;
    #1;
    n_total++; if ({dbg_gnt, if_gnt, mem_gnt} !== 3'b100) $display("FAIL halt_dbg_follow: got dg=%b ig=%b mg=%b want 1 0 0", dbg_gnt, if_gnt, mem_gnt); else n_pass++;
    tick();
    dbg_req = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    #3;
    n_total++; if (dbg_rvalid !== 1'b0) $display("FAIL halt_dbg_wr_no_rvalid: got %b want 0", dbg_rvalid); else n_pass++;
  endtask

  task automatic test_toggle();
    cpu_en = 1'b1;
    tick();
    cpu_en = 1'b0;
    tick();
    cpu_en = 1'b1; if_req = 1'b1; if_addr = 30'h10;
    #3;
    n_total++; if ({if_gnt, if_stall} !== 2'b01) $display("FAIL toggle_halt: got gnt=%b stall=%b want 0 1", if_gnt, if_stall); else n_pass++;
    tick();
    #3;
    n_total++; if (if_gnt !== 1'b1) $display("FAIL toggle_run: got %b want 1", if_gnt); else n_pass++;
    tick();
    if_req = 1'b0;
  endtask

  task automatic test_reset_drop();
    if_req = 1'b1; if_addr = 30'h10;
    #3;
    n_total++; if (if_gnt !== 1'b1) $display("FAIL rdrop_gnt: got %b want 1", if_gnt); else n_pass++;
    tick();
    if_req = 1'b0; reset = 1'b1; cpu_en = 1'b0;
    #3;
    n_total++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h0}) $display("FAIL rdrop_rvalid: got v=%b d=%h want 0 0", if_rvalid, if_rdata); else n_pass++;
    tick();
    reset = 1'b0;
    #3;
    n_total++; if ({if_rvalid, spm_as_, if_gnt, mem_gnt} !== 4'b0100)
      $display("FAIL rdrop_after: got v=%b as_=%b ig=%b mg=%b want 0 1 0 0", if_rvalid, spm_as_, if_gnt, mem_gnt); else n_pass++;
    dbg_req = 1'b1; dbg_rw = READ; dbg_addr = 30'h10;
    #1;
    n_total++; if (dbg_gnt !== 1'b1) $display("FAIL rdrop_halt: got dbg_gnt=%b want 1", dbg_gnt); else n_pass++;
    tick();
    dbg_req = 1'b0;
  endtask

  task automatic test_fairness();
    logic exp_if;
    cpu_en = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 30'h10;
    mem_req = 1'b1; mem_rw = READ; mem_addr = 30'h20;
    for (int c = 1; c <= 8; c++) begin
      exp_if = FAIR && (c == 5);
      #3;
      n_total++; if ({if_gnt, mem_gnt} !== {exp_if, ~exp_if})
        $display("FAIL fair_cycle%0d: got ig=%b mg=%b want %b %b", c, if_gnt, mem_gnt, exp_if, ~exp_if); else n_pass++;
      tick();
    end
    if_req = 1'b0; mem_req = 1'b0; cpu_en = 1'b0;
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[16] = 32'hDEADBEEF;
    spm_rdata = '0;
    test_reset();
    test_if_read();
    test_priority();
    test_drain();
    test_halt_stall();
    test_toggle();
    test_reset_drop();
    test_fairness();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_spm_arbiter
